// File: rtl/if_fetch_unit_if.sv
// Instruction-bus bundle between the fetch unit (master) and instruction memory (slave).
// Single-outstanding request/ack handshake; ack qualifies data for the address presented.
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;

    modport master (
        output req,
        output addr,
        input  ack,
        input  data
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit: owns the PC, runs the instruction-bus handshake and offers
// pc/instruction to the IF/ID register, with stall, branch and flush redirection.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   flush,
    input  logic [31:0]            new_pc,
    input  logic                   branch_flag_i,
    input  logic [31:0]            branch_target_address_i,
    if_fetch_unit_if.master        ibus,
    output logic [31:0]            if_pc,
    output logic [31:0]            if_inst,
    output logic                   if_adel_o,
    output logic                   stallreq_from_if
);

    typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;

    logic        misaligned;
    logic        fetch_done;
    logic [31:0] next_pc;

    // Only bit 0 of the ctrl stall vector concerns this stage.
    logic        unused_stall;
    assign unused_stall = ^stall[5:1];

    assign misaligned = (pc_q[1:0] != 2'b00);
    // A misaligned fetch never goes on the bus, so it completes at once.
    assign fetch_done = (state_q == StReq) && (misaligned || ibus.ack);
    assign next_pc    = branch_flag_i ? branch_target_address_i : pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            inst_buf_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_buf_q <= inst_buf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_buf_d = inst_buf_q;
        if (flush) begin
            state_d    = StReq;
            pc_d       = new_pc;
            inst_buf_d = 32'h0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StReq;
                StReq: begin
                    if (fetch_done) begin
                        if (!stall[0]) begin
                            pc_d = next_pc;
                        end else begin
                            inst_buf_d = misaligned ? 32'h0 : ibus.data;
                            state_d    = StHold;
                        end
                    end
                end
                StHold: begin
                    if (!stall[0]) begin
                        pc_d    = next_pc;
                        state_d = StReq;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are forced low during reset regardless of the registered state.
    always_comb begin
        ibus.req         = 1'b0;
        ibus.addr        = 32'h0;
        if_pc            = 32'h0;
        if_inst          = 32'h0;
        if_adel_o        = 1'b0;
        stallreq_from_if = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle: ;
                StReq: begin
                    ibus.req         = !misaligned;
                    ibus.addr        = pc_q;
                    if_pc            = pc_q;
                    if_adel_o        = misaligned;
                    if_inst          = (ibus.ack && !misaligned && !flush) ? ibus.data : 32'h0;
                    stallreq_from_if = !misaligned && !ibus.ack && !flush;
                end
                StHold: begin
                    ibus.addr = pc_q;
                    if_pc     = pc_q;
                    if_adel_o = misaligned;
                    if_inst   = flush ? 32'h0 : inst_buf_q;
                end
                default: ;
            endcase
        end
    end

endmodule
